uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the existing `uart` transmitter.
- Runs in the clk100 domain.
- Samples an asynchronous serial pin and delivers one byte at a time through a level valid/ack holding register.
- Flags framing errors and overruns.
- Feeds future host-command parsers, e.g. UART-driven SDRAM read/write test control.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (868), clock cycles per bit. Simulation overrides it to 16. Minimum legal value is 8.

Ports:
- clk  in  1  system clock (clk100).
- rst  in  1  reset; synchronous, active-high.
- rx_pin  in  1  asynchronous serial input; idle high.
- rx_byte  out  8  received data, LSB first on the wire.
- rx_valid  out  1  level; high while rx_byte holds an unconsumed byte.
- rx_ack  in  1  consumer strobe; clears rx_valid.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- overrun  out  1  one-cycle pulse when a byte completes while rx_valid=1 and rx_ack=0.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - rx_byte=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - State=IDLE, bit counter=0, baud counter=0.
  - Both synchronizer flops=1 (idle line).
- Reset asserted mid-frame aborts the frame immediately. No partial byte is delivered and no error pulse is produced.
- rx_pin passes through a 2-flop synchronizer; rxs is its output. Every timing below is measured from rxs.
- HALF = CLKS_PER_BIT/2, using integer division.
- Baud counter width is $clog2(CLKS_PER_BIT). The counter is reloaded to 0 on every state entry.
- States:
  - IDLE: on rxs=0, go to START with cnt=0.
  - START: when cnt=HALF-1, sample rxs.
    - rxs=0: go to DATA, bit=0.
    - rxs=1: false start; return to IDLE with no pulse.
  - DATA: every CLKS_PER_BIT cycles, shift rxs into shreg[7] (right shift) and increment bit.
    - After bit 7 is sampled, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rxs.
    - rxs=1: deliver the byte and go to IDLE.
    - rxs=0: pulse frame_err, discard the byte, go to BREAK.
  - BREAK: wait for rxs=1, then go to IDLE. This prevents a held-low line from re-triggering start.
- Sample points from the cycle rxs first reads 0 (cycle 0):
  - Start check at cycle HALF-1.
  - Data bit i at HALF-1+(i+1)*CLKS_PER_BIT.
  - Stop bit at HALF-1+9*CLKS_PER_BIT.
- Delivery:
  - On the cycle after the stop sample, rx_byte=shreg and rx_valid=1.
  - Next-frame detection is possible from the cycle after the stop sample.
- Handshake:
  - rx_ack with rx_valid=1 clears rx_valid on the next edge.
  - rx_ack with rx_valid=0 is ignored.
- Simultaneous delivery and rx_ack: the new byte loads, rx_valid stays 1, and there is no overrun.
- Overrun (delivery while rx_valid=1 and rx_ack=0):
  - The old rx_byte is kept and the new byte is dropped.
  - overrun pulses for 1 cycle.
  - rx_valid stays 1.
- frame_err and overrun never assert in the same cycle. A framing error takes priority because nothing is delivered.

Decomposition:
- Shared package uart_pkg:
  - State encoding constants: RX_IDLE=0, RX_START=1, RX_DATA=2, RX_STOP=3, RX_BREAK=4.
  - Default CLK_FREQ and BAUD, shared with `uart` so both ends agree on the rate.
- One sub-module: sync_2ff.
  - Parameterised reset value, set to 1 here.
  - Reused for any other asynchronous input in the codebase.

Test Plan:
- CLKS_PER_BIT=16. Drive 0xA5 as an 8N1 frame, with no ack during the frame.
  - -> rx_valid rises 2+7+144+1 cycles after the pin falls; rx_byte=8'hA5; busy is high throughout the frame.
  - -> Then pulse rx_ack -> rx_valid=0 on the next cycle.
- Low glitch of 4 cycles on an idle line -> START rejects it at the check; back to IDLE; no rx_valid, no error pulse.
- Send 0x3C with the stop bit held low for 40 cycles, then high.
  - -> frame_err pulses once; rx_valid stays 0; FSM stays in BREAK until the line is high.
  - -> A following 0x5A frame is received correctly.
- Back-to-back 0x11 then 0x22 with no ack -> rx_byte=0x11 is kept; overrun pulses once at the second delivery; rx_valid=1.
- Back-to-back 0x33 then 0x44 with rx_ack asserted exactly on the second delivery cycle -> rx_byte=0x44; rx_valid=1; no overrun.
- Assert rst for 1 cycle during data bit 4 of 0xFF, then send 0x81 -> all outputs are at reset values after rst; only 0x81 is delivered.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and receiver so both ends agree
// on the line rate and the receiver state encoding.
//   UART_CLK_FREQ : default system clock frequency in Hz (clk100).
//   UART_BAUD     : default line rate in bit/s.
//   rx_state_e    : receiver FSM state encoding.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_CLK_FREQ = 100_000_000;
  localparam int UART_BAUD     = 115_200;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous input.
//   clk : destination clock
//   rst : synchronous active-high reset; both flops load RST_VAL
//   d   : asynchronous input
//   q   : synchronized output (two clock edges of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver. The serial pin is synchronized, each frame is sampled at
// the centre of every bit, and the received byte is presented through a level
// valid/ack holding register.
//   clk       : system clock (clk100)
//   rst       : synchronous active-high reset
//   rx_pin    : asynchronous serial input, idle high
//   rx_byte   : received data (LSB first on the wire)
//   rx_valid  : high while rx_byte holds an unconsumed byte
//   rx_ack    : consumer strobe, clears rx_valid
//   frame_err : one-cycle pulse when the stop bit is sampled low
//   overrun   : one-cycle pulse when a byte completes while the previous one
//               is still unconsumed and not being acked
//   busy      : high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = UART_CLK_FREQ,
  parameter int BAUD         = UART_BAUD,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int HALF  = CLKS_PER_BIT / 2;

  // The IDLE cycle that first sees rxs low is cycle 0 of the half bit, and
  // the counter only starts at 0 in the following cycle, so the start-bit
  // centre (cycle HALF-1 from detection) is reached at count HALF-2.
  localparam logic [CNT_W-1:0] START_CHK = CNT_W'(HALF - 2);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic rxs;

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             deliver;
  logic             stop_bad;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx_pin),
    .q  (rxs)
  );

  // Frame FSM: next state, bit sampling and end-of-frame events.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    deliver  = 1'b0;
    stop_bad = 1'b0;

    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rxs) begin
          state_d = RX_START;
        end
      end

      RX_START: begin
        if (cnt_q == START_CHK) begin
          cnt_d = '0;
          if (!rxs) begin
            state_d = RX_DATA;
            bit_d   = 3'd0;
          end else begin
            // Line went back high before the start-bit centre: a glitch.
            state_d = RX_IDLE;
          end
        end
      end

      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rxs, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end
        end
      end

      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            deliver = 1'b1;
            state_d = RX_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = RX_BREAK;
          end
        end
      end

      RX_BREAK: begin
        // Hold off until the line returns high so a stuck-low line cannot
        // look like a stream of start bits.
        cnt_d = '0;
        if (rxs) begin
          state_d = RX_IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = RX_IDLE;
      end
    endcase
  end

  // Holding register and status pulses. A framing error delivers nothing,
  // so it can never coincide with an overrun.
  always_comb begin
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = stop_bad;
    overrun_d   = 1'b0;

    if (deliver) begin
      if (rx_valid_q && !rx_ack) begin
        overrun_d = 1'b1;
      end else begin
        rx_byte_d  = shreg_q;
        rx_valid_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ack) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      shreg_q     <= 8'd0;
      rx_byte_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Bench for uart_rx with CLKS_PER_BIT=16. A reference model computes the
// expected outputs from the bit sample offsets measured from the first low
// synchronized sample; outputs are compared every cycle plus directed checks.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB      = 16;
  localparam int HALF     = CPB / 2;
  localparam int STOP_OFS = HALF - 1 + 9 * CPB;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       rx_pin = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_pin   (rx_pin),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  bit         m_s1 = 1'b1, m_s2 = 1'b1;
  bit         m_active = 1'b0, m_brk = 1'b0;
  bit         m_r, m_dlv, m_bad;
  int         m_t = 0, m_fs = 0, m_k;
  logic [7:0] m_byte = 8'd0;
  logic [7:0] e_byte = 8'd0;
  bit         e_valid = 1'b0, e_ferr = 1'b0, e_ovr = 1'b0, e_busy = 1'b0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_s1 = 1'b1; m_s2 = 1'b1;
      m_active = 1'b0; m_brk = 1'b0;
      e_byte = 8'd0; e_valid = 1'b0; e_ferr = 1'b0; e_ovr = 1'b0; e_busy = 1'b0;
    end else begin
      m_r = m_s2; m_dlv = 1'b0; m_bad = 1'b0;
      if (m_active) begin
        m_k = (m_t - m_fs) - (HALF - 1);
        if (m_k == 0) begin
          if (m_r) m_active = 1'b0;
        end else if (m_k > 0 && (m_k % CPB) == 0 && (m_k / CPB) <= 8) begin
          m_byte[m_k / CPB - 1] = m_r;
        end else if (m_k + (HALF - 1) == STOP_OFS) begin
          m_active = 1'b0;
          if (m_r) m_dlv = 1'b1;
          else begin
            m_bad = 1'b1;
            m_brk = 1'b1;
          end
        end
      end else if (m_brk) begin
        if (m_r) m_brk = 1'b0;
      end else if (!m_r) begin
        m_active = 1'b1;
        m_fs     = m_t;
      end

      e_ferr = m_bad;
      e_ovr  = 1'b0;
      if (m_dlv) begin
        if (e_valid && !rx_ack) e_ovr = 1'b1;
        else begin
          e_byte  = m_byte;
          e_valid = 1'b1;
        end
      end else if (e_valid && rx_ack) begin
        e_valid = 1'b0;
      end
      e_busy = m_active || m_brk;

      m_s2 = m_s1;
      m_s1 = rx_pin;
    end
    m_t++;
  end

  // ---------------- per-cycle monitor ----------------
  bit mon_en = 1'b0;
  bit prev_valid = 1'b0;
  int n_rise = 0, n_ferr = 0, n_ovr = 0;

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("rx_valid",  32'(rx_valid),  32'(e_valid));
      chk("rx_byte",   32'(rx_byte),   32'(e_byte));
      chk("frame_err", 32'(frame_err), 32'(e_ferr));
      chk("overrun",   32'(overrun),   32'(e_ovr));
      chk("busy",      32'(busy),      32'(e_busy));
      if (rx_valid && !prev_valid) n_rise++;
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
      prev_valid = rx_valid;
    end
  end

  // ---------------- ack driver ----------------
  bit ack_rand_en = 1'b0;
  bit ack_manual  = 1'b0;
  int ack_at      = -1;

  initial forever begin
    @(posedge clk);
    #2;
    if (ack_rand_en) rx_ack = ($urandom_range(0, 7) == 0);
    else             rx_ack = ack_manual || (cyc == ack_at);
  end

  // ---------------- stimulus helpers ----------------
  int fall_cyc = 0;

  task automatic send_frame(input logic [7:0] b, input int stop_low);
    fall_cyc = cyc;
    rx_pin = 1'b0;
    repeat (CPB) tick;
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      repeat (CPB) tick;
    end
    if (stop_low > 0) begin
      rx_pin = 1'b0;
      repeat (stop_low) tick;
    end
    rx_pin = 1'b1;
    repeat (CPB) tick;
  endtask

  task automatic wait_valid(input int bound, output int seen);
    seen = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (rx_valid === 1'b1) begin
        seen = cyc;
        break;
      end
    end
  endtask

  task automatic pulse_ack;
    ack_manual = 1'b1;
    tick;
    ack_manual = 1'b0;
    @(negedge clk);
    chk("ack_clears_valid", 32'(rx_valid), 32'd0);
    #4;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int seen, r0, f0, o0, kind, len;

    rst = 1'b1;
    repeat (3) tick;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(rx_valid),  32'd0);
    chk("rst_byte",  32'(rx_byte),   32'd0);
    chk("rst_ferr",  32'(frame_err), 32'd0);
    chk("rst_ovr",   32'(overrun),   32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    #4;
    rst = 1'b0;
    repeat (5) tick;

    // 0xA5 with fixed latency from pin fall to rx_valid
    fork
      send_frame(8'hA5, 0);
      wait_valid(300, seen);
    join
    chk("a5_latency", 32'(seen - fall_cyc), 32'd154);
    chk("a5_byte", 32'(rx_byte), 32'hA5);
    pulse_ack();
    repeat (4) tick;

    // short low glitch on an idle line
    r0 = n_rise; f0 = n_ferr;
    rx_pin = 1'b0;
    repeat (4) tick;
    rx_pin = 1'b1;
    repeat (40) tick;
    chk("glitch_no_valid", 32'(n_rise - r0), 32'd0);
    chk("glitch_no_ferr",  32'(n_ferr - f0), 32'd0);
    @(negedge clk);
    chk("glitch_idle", 32'(busy), 32'd0);
    #4;

    // stop bit held low -> framing error and break, then a good frame
    r0 = n_rise; f0 = n_ferr;
    fork
      send_frame(8'h3C, 40);
      begin
        repeat (170) tick;
        @(negedge clk);
        chk("break_busy", 32'(busy), 32'd1);
      end
    join
    repeat (5) tick;
    chk("break_ferr_once", 32'(n_ferr - f0), 32'd1);
    chk("break_no_valid",  32'(n_rise - r0), 32'd0);
    send_frame(8'h5A, 0);
    repeat (4) tick;
    chk("after_break_byte", 32'(rx_byte), 32'h5A);
    chk("after_break_valid", 32'(rx_valid), 32'd1);
    pulse_ack();

    // back-to-back without ack -> overrun, first byte kept
    o0 = n_ovr;
    send_frame(8'h11, 0);
    send_frame(8'h22, 0);
    repeat (4) tick;
    chk("ovr_byte_kept", 32'(rx_byte), 32'h11);
    chk("ovr_valid", 32'(rx_valid), 32'd1);
    chk("ovr_once", 32'(n_ovr - o0), 32'd1);
    pulse_ack();

    // ack exactly on the second delivery cycle -> new byte loads, no overrun
    o0 = n_ovr;
    send_frame(8'h33, 0);
    ack_at = cyc + STOP_OFS + 2;
    send_frame(8'h44, 0);
    ack_at = -1;
    repeat (4) tick;
    chk("ackdlv_byte", 32'(rx_byte), 32'h44);
    chk("ackdlv_valid", 32'(rx_valid), 32'd1);
    chk("ackdlv_no_ovr", 32'(n_ovr - o0), 32'd0);

    // reset during data bit 4 of 0xFF, then 0x81
    fork
      send_frame(8'hFF, 0);
      begin
        repeat (88) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(rx_valid),  32'd0);
        chk("midrst_byte",  32'(rx_byte),   32'd0);
        chk("midrst_busy",  32'(busy),      32'd0);
        chk("midrst_ferr",  32'(frame_err), 32'd0);
        chk("midrst_ovr",   32'(overrun),   32'd0);
        r0 = n_rise;
      end
    join
    repeat (10) tick;
    send_frame(8'h81, 0);
    repeat (4) tick;
    chk("midrst_one_delivery", 32'(n_rise - r0), 32'd1);
    chk("midrst_byte81", 32'(rx_byte), 32'h81);
    pulse_ack();

    // randomized traffic with random acks, glitches and bad stop bits
    ack_rand_en = 1'b1;
    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        len = $urandom_range(1, 10);
        rx_pin = 1'b0;
        repeat (len) tick;
        rx_pin = 1'b1;
        repeat (CPB * 11) tick;
      end else if (kind == 1) begin
        send_frame(8'($urandom), $urandom_range(1, 40));
      end else begin
        send_frame(8'($urandom), 0);
      end
      repeat ($urandom_range(0, 12)) tick;
    end
    ack_rand_en = 1'b0;
    repeat (40) tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
